// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl
// Single-service DMA bus-cycle sequencer for an 8237A-style controller.
// It walks the bus states SI/S0/S1/S2/S3/SW/S4 and holds the current
// address and word count. It also produces the bus control levels that
// the datapath stage gates onto the pins.
//
// Parameters
//   AW : address / count register width (>= 9)
//   UW : width of the upper address byte presented during ADSTB
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   dreq_valid          resolved channel request (starts a service from SI)
//   dreq_active         live DREQ level, polled at S4 in demand mode
//   HLDA                CPU hold acknowledge (advances S0 -> S1)
//   READY               low at S3/SW inserts wait states
//   eop_in_n            external EOP, active-low, latched as terminate
//   xfer_type           00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 verify
//   svc_mode            00 demand, 01 single, 10 block, 11 single
//   addr_dec            1 = decrement address after each transfer
//   ld_en/ld_addr/ld_count  base register load, honoured only in SI
//   hrq, dack, aen, adstb   bus control, active-high
//   ior, iow, memr, memw    bus strobes, active-low
//   eop                 active-low terminal-count pulse during S4
//   addr_out, addr_hi   current address and its upper byte
//   tc                  sticky terminal-count flag
//   busy                sequencer is outside SI
//
// Every output is a flop loaded from the next-state value, so no output
// has a combinational path from an input.

module dma_timing_ctrl #(
  parameter int AW = 16,
  parameter int UW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          dreq_valid,
  input  logic          dreq_active,
  input  logic          HLDA,
  input  logic          READY,
  input  logic          eop_in_n,
  input  logic [1:0]    xfer_type,
  input  logic [1:0]    svc_mode,
  input  logic          addr_dec,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] ld_count,
  output logic          hrq,
  output logic          dack,
  output logic          aen,
  output logic          adstb,
  output logic          ior,
  output logic          iow,
  output logic          memr,
  output logic          memw,
  output logic          eop,
  output logic [AW-1:0] addr_out,
  output logic [UW-1:0] addr_hi,
  output logic          tc,
  output logic          busy
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] count_q;
  logic [AW-1:0] addr_upd;
  logic          term_q;
  logic          is_wr;
  logic          is_rd;
  logic          tc_hit;
  logic          byte_carry;
  logic          term_now;
  logic          stop_after;
  logic          in_active;

  assign is_wr      = (xfer_type == 2'b01);
  assign is_rd      = (xfer_type == 2'b10);
  assign addr_upd   = addr_dec ? (addr_q - ONE) : (addr_q + ONE);
  // A change in the upper address bits means the external latch holding
  // A15..A8 is stale, so the next transfer must pass through S1 again.
  assign byte_carry = (addr_upd[AW-1:8] != addr_q[AW-1:8]);
  // Terminal count is judged on the count before its S4 decrement, so a
  // programmed count N moves N+1 words.
  assign tc_hit     = (count_q == '0);
  // An EOP arriving in S4 itself still ends the service after this cycle.
  assign term_now   = term_q | ~eop_in_n;
  assign stop_after = tc_hit | term_now | svc_mode[0] |
                      ((svc_mode == 2'b00) & ~dreq_active);
  assign in_active  = (state inside {S1, S2, S3, SW, S4});

  assign addr_out = addr_q;
  assign addr_hi  = addr_q[UW+7:8];

  always_comb begin
    state_nxt = state;
    case (state)
      SI:      if (dreq_valid && !ld_en) state_nxt = S0;
      S0:      if (HLDA) state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3, SW:  state_nxt = READY ? S4 : SW;
      S4: begin
        if (stop_after)      state_nxt = SI;
        else if (byte_carry) state_nxt = S1;
        else                 state_nxt = S2;
      end
      default: state_nxt = SI;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= SI;
      addr_q  <= '0;
      count_q <= '0;
      term_q  <= 1'b0;
      tc      <= 1'b0;
      hrq     <= 1'b0;
      busy    <= 1'b0;
      aen     <= 1'b0;
      adstb   <= 1'b0;
      dack    <= 1'b0;
      ior     <= 1'b1;
      iow     <= 1'b1;
      memr    <= 1'b1;
      memw    <= 1'b1;
      eop     <= 1'b1;
    end else begin
      state <= state_nxt;

      if (state == SI && ld_en) begin
        addr_q  <= ld_addr;
        count_q <= ld_count;
      end else if (state == S4) begin
        addr_q  <= addr_upd;
        count_q <= count_q - ONE;
      end

      if (state == SI)
        term_q <= 1'b0;
      else if (in_active && !eop_in_n)
        term_q <= 1'b1;

      if (state == SI && ld_en)
        tc <= 1'b0;
      else if (state_nxt == S4 && tc_hit)
        tc <= 1'b1;

      hrq   <= (state_nxt != SI);
      busy  <= (state_nxt != SI);
      aen   <= (state_nxt inside {S1, S2, S3, SW, S4});
      adstb <= (state_nxt == S1);
      dack  <= (state_nxt inside {S2, S3, SW, S4});
      ior   <= ~(is_wr && (state_nxt inside {S2, S3, SW}));
      memr  <= ~(is_rd && (state_nxt inside {S2, S3, SW}));
      memw  <= ~(is_wr && (state_nxt inside {S3, SW}));
      iow   <= ~(is_rd && (state_nxt inside {S3, SW}));
      eop   <= ~((state_nxt == S4) && tc_hit);
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Testbench for dma_timing_ctrl: scripted and randomized DMA services
// checked cycle by cycle against a transfer-level model of the bus cycle.

module tb_dma_timing_ctrl;
  localparam int AW = 16;
  localparam int UW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          dreq_valid = 1'b0;
  logic          dreq_active = 1'b1;
  logic          HLDA = 1'b0;
  logic          READY = 1'b1;
  logic          eop_in_n = 1'b1;
  logic [1:0]    xfer_type = 2'b00;
  logic [1:0]    svc_mode = 2'b00;
  logic          addr_dec = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [AW-1:0] ld_count = '0;
  logic          hrq, dack, aen, adstb, ior, iow, memr, memw, eop, tc, busy;
  logic [AW-1:0] addr_out;
  logic [UW-1:0] addr_hi;

  dma_timing_ctrl #(.AW(AW), .UW(UW)) dut (
    .CLK(CLK), .RESET(RESET), .dreq_valid(dreq_valid), .dreq_active(dreq_active),
    .HLDA(HLDA), .READY(READY), .eop_in_n(eop_in_n), .xfer_type(xfer_type),
    .svc_mode(svc_mode), .addr_dec(addr_dec), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_count(ld_count), .hrq(hrq), .dack(dack), .aen(aen), .adstb(adstb),
    .ior(ior), .iow(iow), .memr(memr), .memw(memw), .eop(eop),
    .addr_out(addr_out), .addr_hi(addr_hi), .tc(tc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef enum int {P_SI, P_S0, P_S1, P_S2, P_S3, P_SW, P_S4} phase_t;

  phase_t      cur_phase = P_SI;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_count = 16'h0000;
  logic        m_tc = 1'b0;
  logic [1:0]  cur_xt = 2'b00;
  logic [34:0] exp_v = '0;
  bit          exp_on = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          adstb_seen = 0;
  int          eop_seen = 0;
  int          memw_lo = 0;
  logic [7:0]  lows [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};

  wire [34:0] dut_v = {hrq, dack, aen, adstb, ior, iow, memr, memw, eop, tc, busy,
                       addr_out, addr_hi};

  always @(negedge CLK) begin
    if (exp_on) begin
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_%s t=%0t got=%h want=%h", cur_phase.name(), $time, dut_v, exp_v);
      end
    end
    if (adstb === 1'b1) adstb_seen++;
    if (eop === 1'b0)   eop_seen++;
    if (memw === 1'b0)  memw_lo++;
  end

  // Bus-state table: which levels each bus state shows for the current transfer type.
  function automatic logic [34:0] model_out(input phase_t p);
    logic act, rd_ph, wr_ph, ior_e, iow_e, memr_e, memw_e, eop_e;
    act    = (p != P_SI);
    rd_ph  = (p == P_S2) || (p == P_S3) || (p == P_SW);
    wr_ph  = (p == P_S3) || (p == P_SW);
    ior_e  = !(cur_xt == 2'b01 && rd_ph);
    memr_e = !(cur_xt == 2'b10 && rd_ph);
    memw_e = !(cur_xt == 2'b01 && wr_ph);
    iow_e  = !(cur_xt == 2'b10 && wr_ph);
    eop_e  = !(p == P_S4 && m_count == 16'h0000);
    return {act, (rd_ph || p == P_S4), (rd_ph || p == P_S4 || p == P_S1), (p == P_S1),
            ior_e, iow_e, memr_e, memw_e, eop_e, m_tc, act, m_addr, m_addr[15:8]};
  endfunction

  task automatic chk(input string name, input logic [34:0] got, input logic [34:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input phase_t p);
    @(posedge CLK);
    #1;
    cur_phase = p;
    if (p == P_S4 && m_count == 16'h0000) m_tc = 1'b1;
    exp_v  = model_out(p);
    exp_on = 1'b1;
  endtask

  // Called from inside an SI cycle; returns inside the following SI cycle.
  task automatic load(input logic [15:0] a, input logic [15:0] c, input bit with_dreq);
    ld_en = 1'b1; ld_addr = a; ld_count = c; dreq_valid = with_dreq;
    m_addr = a; m_count = c; m_tc = 1'b0;
    cyc(P_SI);
    ld_en = 1'b0; dreq_valid = 1'b0;
  endtask

  // One service from request to the return to SI. Called from inside an SI cycle.
  task automatic service(input logic [1:0] xt, input logic [1:0] md, input logic dec,
                         input int hlda_dly, input int eop_xfer, input int drop_xfer,
                         input int fixed_wait, output int nx, output int ns1);
    int k, w;
    bit need_s1, done, tc_now, term;
    logic [15:0] nxt;
    cur_xt = xt; xfer_type = xt; svc_mode = md; addr_dec = dec;
    dreq_active = 1'b1; dreq_valid = 1'b1;
    cyc(P_S0);
    dreq_valid = 1'b0;
    HLDA = (hlda_dly == 0);
    for (int i = 0; i < hlda_dly; i++) begin
      cyc(P_S0);
      HLDA = (i == hlda_dly - 1);
    end
    need_s1 = 1'b1; done = 1'b0; k = 0; ns1 = 0;
    while (!done) begin
      if (need_s1) begin
        cyc(P_S1);
        ns1++;
      end
      cyc(P_S2);
      if (k == eop_xfer)  eop_in_n = 1'b0;
      if (k == drop_xfer) dreq_active = 1'b0;
      if ($urandom_range(3) == 0) begin
        ld_en = 1'b1; ld_addr = 16'($urandom); ld_count = 16'($urandom);
      end
      w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(2));
      cyc(P_S3);
      eop_in_n = 1'b1; ld_en = 1'b0;
      READY = (w == 0);
      for (int j = 0; j < w; j++) begin
        cyc(P_SW);
        READY = (j == w - 1);
      end
      cyc(P_S4);
      READY = 1'b1;
      tc_now  = (m_count == 16'h0000);
      term    = (k == eop_xfer);
      nxt     = dec ? m_addr - 16'd1 : m_addr + 16'd1;
      need_s1 = (nxt[15:8] != m_addr[15:8]);
      m_addr  = nxt;
      m_count = m_count - 16'd1;
      k++;
      done = tc_now || term || (md == 2'b01) || (md == 2'b11) ||
             (md == 2'b00 && !dreq_active);
      if (k > 40) begin
        $display("FAIL service_runaway transfers=%0d limit=40", k);
        errors++;
        done = 1'b1;
      end
    end
    HLDA = 1'b0;
    nx = k;
    cyc(P_SI);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nx, ns1, a0, e0, w0, r;
    logic [15:0] ra;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", dut_v, 35'h07C000000);
    RESET = 1'b0;
    cyc(P_SI);

    // Single write, count 0, HLDA after 2 cycles
    load(16'h1234, 16'd0, 1'b0);
    chk("t1_addr_hi_loaded", 35'(addr_hi), 35'h12);
    service(2'b01, 2'b01, 1'b0, 2, -1, -1, -1, nx, ns1);
    chk("t1_model_addr", 35'(m_addr), 35'h1235);
    chk("t1_addr", 35'(addr_out), 35'h1235);
    chk("t1_tc", 35'(tc), 35'd1);
    chk("t1_xfers", 35'(nx), 35'd1);

    // Block read across the 0x00FF -> 0x0100 boundary
    load(16'h00FE, 16'd2, 1'b0);
    a0 = adstb_seen; e0 = eop_seen;
    service(2'b10, 2'b10, 1'b0, 0, -1, -1, -1, nx, ns1);
    chk("t2_xfers", 35'(nx), 35'd3);
    chk("t2_model_s1", 35'(ns1), 35'd2);
    chk("t2_adstb_pulses", 35'(adstb_seen - a0), 35'd2);
    chk("t2_eop_pulses", 35'(eop_seen - e0), 35'd1);
    chk("t2_addr", 35'(addr_out), 35'h0101);

    // Three READY wait states
    load(16'h3000, 16'd1, 1'b0);
    w0 = memw_lo;
    service(2'b01, 2'b01, 1'b0, 1, -1, -1, 3, nx, ns1);
    chk("t3_memw_low_cycles", 35'(memw_lo - w0), 35'd4);
    chk("t3_addr", 35'(addr_out), 35'h3001);

    // External EOP in S2 of transfer 2
    load(16'h5000, 16'd10, 1'b0);
    e0 = eop_seen;
    service(2'b10, 2'b10, 1'b0, 0, 1, -1, -1, nx, ns1);
    chk("t4_xfers", 35'(nx), 35'd2);
    chk("t4_model_count", 35'(m_count), 35'd8);
    chk("t4_tc", 35'(tc), 35'd0);
    chk("t4_eop_pulses", 35'(eop_seen - e0), 35'd0);

    // Demand mode, DREQ drops during transfer 3, then resumes
    load(16'h2000, 16'd10, 1'b0);
    service(2'b01, 2'b00, 1'b0, 0, -1, 2, -1, nx, ns1);
    chk("t5_xfers", 35'(nx), 35'd3);
    chk("t5_addr", 35'(addr_out), 35'h2003);
    service(2'b01, 2'b00, 1'b0, 0, -1, -1, -1, nx, ns1);
    chk("t5_resume_xfers", 35'(nx), 35'd8);
    chk("t5_resume_addr", 35'(addr_out), 35'h200B);
    chk("t5_resume_tc", 35'(tc), 35'd1);

    // ld_en together with dreq_valid: load wins, no hold request
    load(16'h7777, 16'd3, 1'b1);
    chk("t7_hrq", 35'(hrq), 35'd0);
    chk("t7_addr", 35'(addr_out), 35'h7777);
    cyc(P_SI);

    // Decrement wrap from 0x0000
    load(16'h0000, 16'd0, 1'b0);
    service(2'b00, 2'b01, 1'b1, 0, -1, -1, -1, nx, ns1);
    chk("t8_model_addr", 35'(m_addr), 35'hFFFF);
    chk("t8_addr", 35'(addr_out), 35'hFFFF);

    // Reset in the middle of S3
    load(16'h4321, 16'd3, 1'b0);
    cur_xt = 2'b01; xfer_type = 2'b01; svc_mode = 2'b10; addr_dec = 1'b0;
    dreq_valid = 1'b1;
    cyc(P_S0);
    dreq_valid = 1'b0; HLDA = 1'b1;
    cyc(P_S1);
    cyc(P_S2);
    cyc(P_S3);
    #1;
    RESET = 1'b1;
    m_addr = 16'h0000; m_count = 16'h0000; m_tc = 1'b0;
    exp_v = model_out(P_SI);
    cur_phase = P_SI;
    #1;
    chk("t6_reset_strobes", 35'({ior, iow, memr, memw, busy, hrq, dack, aen}), 35'b11110000);
    HLDA = 1'b0;
    cyc(P_SI);
    RESET = 1'b0;
    cyc(P_SI);

    // Randomized services
    for (int it = 0; it < 25; it++) begin
      if (it == 0 || m_count > 16'd6 || m_tc || $urandom_range(1) == 1) begin
        ra = {8'($urandom_range(255)), lows[$urandom_range(4)]};
        load(ra, 16'($urandom_range(5)), 1'b0);
      end
      r = int'($urandom_range(4));
      service(2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)),
              int'($urandom_range(3)), (r < 2) ? -1 : r - 2,
              ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1, -1, nx, ns1);
    end

    cyc(P_SI);
    @(posedge CLK);
    #1;
    exp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
